// File: rtl/wb_write_scheduler_pkg.sv
// Shared types and helpers for the register-file write-back scheduler.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package wb_write_scheduler_pkg;

  localparam int WB_DATA_W = 64;
  localparam int WB_ADDR_W = 5;
  localparam int NUM_REGS  = 32;

  // One queued register-file write.
  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  // Destination register number to a one-hot register mask.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [WB_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] oh;
    oh     = '0;
    oh[rd] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Load-result FIFO: circular buffer with occupancy count and a pending-destination mask.
// Latency: push visible at head one cycle later; pending_mask is combinational from state.
// Backpressure: caller must not push when full; pop and push may share a cycle.
//
// Ports:
//   clk, reset (async active-low)
//   push / push_rd / push_data : enqueue one entry
//   pop                        : discard the head entry
//   head_rd / head_data        : current head entry (valid when !empty)
//   count / full / empty       : occupancy
//   pending_mask               : OR of one-hot rd over all valid entries
module wb_result_fifo
  import wb_write_scheduler_pkg::*;
#(
  parameter  int DATA_W = WB_DATA_W,
  parameter  int ADDR_W = WB_ADDR_W,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [ADDR_W-1:0]   push_rd,
  input  logic [DATA_W-1:0]   push_data,
  input  logic                pop,
  output logic [ADDR_W-1:0]   head_rd,
  output logic [DATA_W-1:0]   head_data,
  output logic [CNT_W-1:0]    count,
  output logic                full,
  output logic                empty,
  output logic [NUM_REGS-1:0] pending_mask
);

  logic [ADDR_W-1:0] rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only entries inside the count window are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      rd_mem[wr_ptr]   <= push_rd;
      data_mem[wr_ptr] <= push_data;
    end
  end

  assign head_rd   = rd_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // An entry is valid when its distance from rd_ptr is below count. A popped
  // entry drops out at the same edge its write lands in the output register.
  always_comb begin
    logic [PTR_W-1:0] offset;
    pending_mask = '0;
    offset       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr;
      if ({1'b0, offset} < count) begin
        pending_mask = pending_mask | rd_onehot(WB_ADDR_W'(rd_mem[i]));
      end
    end
  end

endmodule

// File: rtl/wb_write_scheduler.sv
// Write-back scheduler: merges ALU results (absolute priority) and queued load results onto one register-file write port.
// Latency: ALU 1 cycle; load 2 cycles minimum (1 cycle with WB_LD_BYPASS_EN when idle and empty), +1 per preempting ALU write.
// Backpressure: ALU has none; loads are valid/ready, ld_ready low while the FIFO is full or reset is asserted.
//
// Optional build macro: WB_LD_BYPASS_EN -- an accepted load goes straight to the
// output register when the ALU is idle and the FIFO is empty.
//
// Ports:
//   clk, reset (async active-low)
//   alu_valid / alu_rd / alu_data       : fixed-latency ALU result, no backpressure
//   ld_valid / ld_ready / ld_rd / ld_data : load result handshake
//   wb_en / wb_addr / wb_data           : registered register-file write port
//   pending_mask                        : registers with a queued load write
//   fifo_count                          : load FIFO occupancy
module wb_write_scheduler
  import wb_write_scheduler_pkg::*;
#(
  parameter  int DATA_W = WB_DATA_W,
  parameter  int ADDR_W = WB_ADDR_W,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [ADDR_W-1:0]   ld_rd,
  input  logic [DATA_W-1:0]   ld_data,
  output logic                wb_en,
  output logic [ADDR_W-1:0]   wb_addr,
  output logic [DATA_W-1:0]   wb_data,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic [CNT_W-1:0]    fifo_count
);

  logic              alu_take;
  logic              ld_take;
  logic              ld_bypass;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;
  logic              nxt_en;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_data;

  // Writes to r0 are architecturally dead: an r0 ALU result is ignored, an r0
  // load is handshaked and then dropped.
  assign alu_take = alu_valid && (alu_rd != '0);
  assign ld_ready = reset && !fifo_full;
  assign ld_take  = ld_valid && ld_ready && (ld_rd != '0);

`ifdef WB_LD_BYPASS_EN
  assign ld_bypass = ld_take && !alu_take && fifo_empty;
`else
  assign ld_bypass = 1'b0;
`endif

  assign fifo_push = ld_take && !ld_bypass;
  // The ALU preempts the head; the head drains only on an idle ALU cycle.
  assign fifo_pop  = !alu_take && !fifo_empty;

  wb_result_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (fifo_push),
    .push_rd      (ld_rd),
    .push_data    (ld_data),
    .pop          (fifo_pop),
    .head_rd      (head_rd),
    .head_data    (head_data),
    .count        (fifo_count),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .pending_mask (pending_mask)
  );

  always_comb begin
    nxt_en   = 1'b0;
    nxt_addr = head_rd;
    nxt_data = head_data;
    if (alu_take) begin
      nxt_en   = 1'b1;
      nxt_addr = alu_rd;
      nxt_data = alu_data;
    end else if (!fifo_empty) begin
      nxt_en   = 1'b1;
    end else if (ld_bypass) begin
      nxt_en   = 1'b1;
      nxt_addr = ld_rd;
      nxt_data = ld_data;
    end
  end

  // Address/data hold their last value on idle cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      wb_en <= nxt_en;
      if (nxt_en) begin
        wb_addr <= nxt_addr;
        wb_data <= nxt_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_write_scheduler.sv
module tb_wb_write_scheduler;
  import wb_write_scheduler_pkg::*;

  localparam int DEPTH = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd    = '0;
  logic [63:0] alu_data  = '0;
  logic        ld_valid  = 1'b0;
  logic [4:0]  ld_rd     = '0;
  logic [63:0] ld_data   = '0;
  logic        ld_ready;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic [31:0] pending_mask;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  wb_write_scheduler #(.DATA_W(64), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_rd        (ld_rd),
    .ld_data      (ld_data),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .pending_mask (pending_mask),
    .fifo_count   (fifo_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an in-order queue of pending loads plus the expected write port.
  wb_entry_t   q[$];
  logic        m_en   = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [63:0] m_data = '0;
  int          m_n;
  bit          m_acc;
  bit          m_byp;
  wb_entry_t   m_e;

  function automatic logic [31:0] q_mask();
    logic [31:0] m;
    m = '0;
    foreach (q[i]) m[q[i].rd] = 1'b1;
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_en   = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else begin
      m_n   = q.size();
      m_acc = ld_valid && (m_n < DEPTH);
      m_byp = 1'b0;
      if (alu_valid && alu_rd != 5'd0) begin
        m_en = 1'b1; m_addr = alu_rd; m_data = alu_data;
      end else if (m_n > 0) begin
        m_e  = q.pop_front();
        m_en = 1'b1; m_addr = m_e.rd; m_data = m_e.data;
      end
`ifdef WB_LD_BYPASS_EN
      else if (m_acc && ld_rd != 5'd0) begin
        m_en = 1'b1; m_addr = ld_rd; m_data = ld_data; m_byp = 1'b1;
      end
`endif
      else begin
        m_en = 1'b0;
      end
      if (m_acc && ld_rd != 5'd0 && !m_byp) q.push_back('{rd: ld_rd, data: ld_data});
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("wb_en",        64'(wb_en),        64'(m_en));
    chk("wb_addr",      64'(wb_addr),      64'(m_addr));
    chk("wb_data",      wb_data,           m_data);
    chk("ld_ready",     64'(ld_ready),     64'(rst_n && (q.size() < DEPTH)));
    chk("pending_mask", 64'(pending_mask), 64'(q_mask()));
    chk("fifo_count",   64'(fifo_count),   64'(q.size()));
  end

  logic [4:0] wlog[$];
  always @(negedge clk) if (wb_en) wlog.push_back(wb_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got=timeout want=done");
    $fatal(1, "watchdog");
  end

  int          ldi;
  logic [4:0]  lows[$];
  int          n10;

  initial begin
    // Reset held with a load offered.
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 64'h33;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ld_ready", 64'(ld_ready), 64'd0);
      chk("rst_wb_en",    64'(wb_en),    64'd0);
    end
    tick();
    idle();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ld_ready", 64'(ld_ready),   64'd1);
    chk("post_rst_count",    64'(fifo_count), 64'd0);

    // Single ALU write, visible exactly one cycle later.
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'hDEAD_BEEF;
    tick();
    idle();
    chk("alu_en",   64'(wb_en),   64'd1);
    chk("alu_addr", 64'(wb_addr), 64'd7);
    chk("alu_data", wb_data,      64'hDEAD_BEEF);
    tick();
    chk("alu_once", 64'(wb_en),   64'd0);

    // ALU busy six cycles while loads rd=1..5 are offered.
    wlog.delete();
    ldi = 1;
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1'b1; alu_rd = 5'(16 + c); alu_data = 64'hA000 + 64'(c);
      ld_valid  = (ldi <= 5); ld_rd = 5'(ldi); ld_data = 64'h1000 + 64'(ldi);
      @(negedge clk);
      if (ld_valid && ld_ready) ldi++;
      tick();
    end
    chk("fill_accepted", 64'(ldi),          64'd5);
    chk("fill_mask",     64'(pending_mask), 64'h1E);
    chk("fill_count",    64'(fifo_count),   64'd4);
    chk("fill_ready",    64'(ld_ready),     64'd0);
    for (int c = 0; c < 12; c++) begin
      alu_valid = 1'b0;
      ld_valid  = (ldi <= 5); ld_rd = 5'(ldi); ld_data = 64'h1000 + 64'(ldi);
      @(negedge clk);
      if (ld_valid && ld_ready) ldi++;
      tick();
    end
    idle();
    chk("rd5_accepted", 64'(ldi), 64'd6);
    lows.delete();
    foreach (wlog[i]) if (wlog[i] < 5'd16) lows.push_back(wlog[i]);
    chk("drain_len", 64'(lows.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < lows.size()) chk("drain_order", 64'(lows[k]), 64'(k + 1));
    end

    // r0 writes from both sources are dropped.
    for (int c = 0; c < 4; c++) begin
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFFFF;
      ld_valid  = 1'b1; ld_rd  = 5'd0; ld_data  = 64'h1234;
      tick();
      chk("r0_wb_en", 64'(wb_en),        64'd0);
      chk("r0_count", 64'(fifo_count),   64'd0);
      chk("r0_mask",  64'(pending_mask), 64'd0);
    end
    idle();
    tick();

    // Queue rd=9,10 behind the ALU, then reset mid-drain.
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 64'h2;
    ld_valid  = 1'b1; ld_rd  = 5'd9; ld_data  = 64'h9;
    tick();
    ld_rd = 5'd10; ld_data = 64'hA;
    tick();
    idle();
    chk("q2_count", 64'(fifo_count),   64'd2);
    chk("q2_mask",  64'(pending_mask), 64'h600);
    tick();
    chk("q9_en",    64'(wb_en),        64'd1);
    chk("q9_addr",  64'(wb_addr),      64'd9);
    chk("q9_mask",  64'(pending_mask), 64'h400);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_en",    64'(wb_en),        64'd0);
    chk("arst_addr",  64'(wb_addr),      64'd0);
    chk("arst_data",  wb_data,           64'd0);
    chk("arst_mask",  64'(pending_mask), 64'd0);
    chk("arst_count", 64'(fifo_count),   64'd0);
    chk("arst_ready", 64'(ld_ready),     64'd0);
    wlog.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    n10 = 0;
    foreach (wlog[i]) if (wlog[i] == 5'd10) n10++;
    chk("no_rd10_after_rst", 64'(n10), 64'd0);

    // Single load into an idle scheduler.
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 64'h55;
    tick();
    idle();
`ifdef WB_LD_BYPASS_EN
    chk("byp_en",   64'(wb_en),        64'd1);
    chk("byp_addr", 64'(wb_addr),      64'd3);
    chk("byp_data", wb_data,           64'h55);
    chk("byp_mask", 64'(pending_mask), 64'd0);
`else
    chk("ld1_en",   64'(wb_en),        64'd0);
    chk("ld1_mask", 64'(pending_mask), 64'h8);
    tick();
    chk("ld2_en",   64'(wb_en),        64'd1);
    chk("ld2_addr", 64'(wb_addr),      64'd3);
    chk("ld2_data", wb_data,           64'h55);
    chk("ld2_mask", 64'(pending_mask), 64'd0);
`endif
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_write_scheduler.md
Name: wb_write_scheduler

Overview:
- Write-back scheduler on the producer side of the 32x64 register file write port.
- Merges fixed-latency ALU results and variable-latency load results into the single write port (wb_en / wb_addr / wb_data), at most one write per cycle.
- ALU results have absolute priority. Load results are buffered in a small FIFO and drained on idle ALU cycles.
- Exports a pending-destination mask so issue logic can stall on registers with queued writes.

Parameters:
- DATA_W, 64, data width of a register.
- ADDR_W, 5, register address width (32 registers).
- DEPTH, 4, load-result FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result present this cycle; no backpressure
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- ld_valid  in  1  load result offered
- ld_ready  out  1  load result accepted when ld_valid && ld_ready
- ld_rd  in  ADDR_W  load destination register
- ld_data  in  DATA_W  load result
- wb_en  out  1  register file write enable (registered)
- wb_addr  out  ADDR_W  register file write address (registered)
- wb_data  out  DATA_W  register file write data (registered)
- pending_mask  out  32  bit i set while any FIFO entry targets register i
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low.
- While reset is low:
  - wb_en=0, wb_addr=0, wb_data=0.
  - FIFO empty; fifo_count=0; pending_mask=0.
  - ld_ready=0.
- Reset asserted mid-operation discards all queued loads. No write is emitted after reset deasserts until new input arrives.
- ld_ready = reset deasserted && (fifo_count < DEPTH). It is combinational from registered count; there is no same-cycle full pass-through.
- Register 0 filter: a handshaked load with ld_rd==0 is consumed but not enqueued. An ALU result with alu_rd==0 is treated as alu_valid=0 for output and arbitration.
- Per-cycle output selection, registered at the clock edge:
  1. ALU has an effective result: wb_en=1, wb_addr=alu_rd, wb_data=alu_data. The FIFO head is held.
  2. Otherwise, FIFO non-empty: the head is popped, wb_en=1 with the head's rd/data.
  3. Otherwise: wb_en=0; wb_addr/wb_data hold their previous values.
- Latency:
  - ALU result to wb_en: 1 cycle.
  - Load result to wb_en: minimum 2 cycles (enqueue, then pop), plus one cycle per ALU write that preempts it.
- FIFO:
  - Circular buffer with rd_ptr/wr_ptr wrapping modulo DEPTH.
  - Push and pop in the same cycle leave fifo_count unchanged. This is legal when full: the pop frees the slot, but ld_ready was 0, so no push occurs.
  - Loads drain strictly in order.
- pending_mask is the OR of the one-hot decode of rd across valid FIFO entries. It is combinational from FIFO state.
  - An entry leaves the mask in the cycle its write appears on wb_en. The register file forwards the write-port value to its read ports, so a register is never reported pending once its write is on the port.
- Same-rd ordering between ALU and queued loads is not resolved here. Issue logic must stall on pending_mask. An ALU write to a pending rd is still performed, and the later load overwrites it.

Optional Feature:
- Macro WB_LD_BYPASS_EN.
- Defined: when the FIFO is empty, the ALU is idle and a nonzero-rd load handshakes, the load goes directly to the output register (wb_en next cycle, 1-cycle latency). It is not enqueued and never appears in pending_mask.
- Undefined: every load passes through the FIFO (minimum 2-cycle latency).

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, NUM_REGS=32, a wb_entry struct {rd, data}, and a function converting rd to a 32-bit one-hot.
- One sub-module: wb_result_fifo. It holds storage, pointers, count, full/empty and pending_mask generation. The top level holds arbitration, the r0 filter and the output register.

Test Plan:
- Reset low for 3 cycles with ld_valid=1 -> ld_ready=0, wb_en=0; after release, ld_ready=1, fifo_count=0.
- ALU result rd=7, data=0xDEAD_BEEF at cycle N -> wb_en=1, wb_addr=7, wb_data=0xDEAD_BEEF at N+1 only.
- ALU valid every cycle for 6 cycles while loads rd=1..5 offered (DEPTH=4):
  - 4 loads accepted, then ld_ready=0 and pending_mask=0x1E.
  - After the ALU stops, writes rd=1,2,3,4 appear on consecutive cycles, then rd=5 is accepted and written.
- Load rd=0 and ALU rd=0 -> never on wb_en; fifo_count stays 0; pending_mask stays 0.
- Queue rd=9,10, then pull reset low mid-drain -> outputs zero immediately (asynchronously); no rd=10 write after release.
- With WB_LD_BYPASS_EN: idle ALU, empty FIFO, load rd=3, data=0x55 at N -> wb_en at N+1, pending_mask stays 0. Without the macro -> wb_en at N+2, pending_mask bit 3 set during N+1.
